// File: rtl/alu_issue_queue.sv
// ALU reservation station: buffers dispatched micro-ops, wakes operands and
// flags from the FU completion broadcast, and issues one ready entry per cycle.
module alu_issue_queue #(
  parameter int RS_SIZE       = 4,
  parameter int GPR_WIDTH     = 64,
  parameter int ROB_IDX_WIDTH = 4,
  parameter int OP_WIDTH      = 4
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic                       in_flush,
  input  logic                       in_disp_valid,
  input  logic [OP_WIDTH-1:0]        in_disp_op,
  input  logic                       in_disp_a_ready,
  input  logic                       in_disp_b_ready,
  input  logic [GPR_WIDTH-1:0]       in_disp_val_a,
  input  logic [GPR_WIDTH-1:0]       in_disp_val_b,
  input  logic [ROB_IDX_WIDTH-1:0]   in_disp_tag_a,
  input  logic [ROB_IDX_WIDTH-1:0]   in_disp_tag_b,
  input  logic                       in_disp_nzcv_ready,
  input  logic [3:0]                 in_disp_nzcv,
  input  logic [ROB_IDX_WIDTH-1:0]   in_disp_nzcv_tag,
  input  logic                       in_disp_set_nzcv,
  input  logic [ROB_IDX_WIDTH-1:0]   in_disp_dst_rob_index,
  output logic                       out_disp_ready,
  input  logic                       in_fu_done,
  input  logic [ROB_IDX_WIDTH-1:0]   in_fu_dst_rob_index,
  input  logic [GPR_WIDTH-1:0]       in_fu_value,
  input  logic                       in_fu_set_nzcv,
  input  logic [3:0]                 in_fu_nzcv,
  input  logic                       in_fu_ready,
  output logic                       out_fu_start,
  output logic [OP_WIDTH-1:0]        out_fu_op,
  output logic [GPR_WIDTH-1:0]       out_fu_val_a,
  output logic [GPR_WIDTH-1:0]       out_fu_val_b,
  output logic [ROB_IDX_WIDTH-1:0]   out_fu_dst_rob_index,
  output logic                       out_fu_set_nzcv,
  output logic [3:0]                 out_fu_nzcv,
  output logic [$clog2(RS_SIZE):0]   out_count
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0]       valid;
  logic [RS_SIZE-1:0]       a_rdy;
  logic [RS_SIZE-1:0]       b_rdy;
  logic [RS_SIZE-1:0]       f_rdy;
  logic [RS_SIZE-1:0]       set_nzcv;
  logic [OP_WIDTH-1:0]      op      [RS_SIZE];
  logic [GPR_WIDTH-1:0]     val_a   [RS_SIZE];
  logic [GPR_WIDTH-1:0]     val_b   [RS_SIZE];
  logic [ROB_IDX_WIDTH-1:0] tag_a   [RS_SIZE];
  logic [ROB_IDX_WIDTH-1:0] tag_b   [RS_SIZE];
  logic [ROB_IDX_WIDTH-1:0] f_tag   [RS_SIZE];
  logic [3:0]               nzcv    [RS_SIZE];
  logic [ROB_IDX_WIDTH-1:0] dst     [RS_SIZE];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             iss_found;
  logic [IDX_W-1:0] iss_idx;
  logic             disp_fire;
  logic             issue_fire;
  logic             byp_a;
  logic             byp_b;
  logic             byp_f;

  assign out_disp_ready = (out_count < CNT_W'(RS_SIZE));

  // Lowest free slot for dispatch and lowest eligible slot for issue, both
  // from registered state so a slot freed by issue is not reused this edge.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    iss_found  = 1'b0;
    iss_idx    = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (valid[i] && a_rdy[i] && b_rdy[i] && f_rdy[i] && !iss_found) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
    end
  end

  // Fire conditions and same-cycle broadcast bypass for the incoming op.
  always_comb begin
    disp_fire  = in_disp_valid && out_disp_ready && !in_flush;
    issue_fire = in_fu_ready && iss_found && !in_flush;
    byp_a = !in_disp_a_ready && in_fu_done && (in_disp_tag_a == in_fu_dst_rob_index);
    byp_b = !in_disp_b_ready && in_fu_done && (in_disp_tag_b == in_fu_dst_rob_index);
    byp_f = !in_disp_nzcv_ready && in_fu_done && in_fu_set_nzcv
            && (in_disp_nzcv_tag == in_fu_dst_rob_index);
  end

  // Entry storage: flush has priority, then wakeup, issue and dispatch.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      valid    <= '0;
      a_rdy    <= '0;
      b_rdy    <= '0;
      f_rdy    <= '0;
      set_nzcv <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op[i]    <= '0;
        val_a[i] <= '0;
        val_b[i] <= '0;
        tag_a[i] <= '0;
        tag_b[i] <= '0;
        f_tag[i] <= '0;
        nzcv[i]  <= '0;
        dst[i]   <= '0;
      end
    end else if (in_flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (valid[i] && in_fu_done) begin
          if (!a_rdy[i] && tag_a[i] == in_fu_dst_rob_index) begin
            a_rdy[i] <= 1'b1;
            val_a[i] <= in_fu_value;
          end
          if (!b_rdy[i] && tag_b[i] == in_fu_dst_rob_index) begin
            b_rdy[i] <= 1'b1;
            val_b[i] <= in_fu_value;
          end
          if (!f_rdy[i] && in_fu_set_nzcv && f_tag[i] == in_fu_dst_rob_index) begin
            f_rdy[i] <= 1'b1;
            nzcv[i]  <= in_fu_nzcv;
          end
        end
      end
      if (issue_fire) begin
        valid[iss_idx] <= 1'b0;
      end
      if (disp_fire) begin
        valid[free_idx]    <= 1'b1;
        op[free_idx]       <= in_disp_op;
        a_rdy[free_idx]    <= in_disp_a_ready || byp_a;
        val_a[free_idx]    <= byp_a ? in_fu_value : in_disp_val_a;
        tag_a[free_idx]    <= in_disp_tag_a;
        b_rdy[free_idx]    <= in_disp_b_ready || byp_b;
        val_b[free_idx]    <= byp_b ? in_fu_value : in_disp_val_b;
        tag_b[free_idx]    <= in_disp_tag_b;
        f_rdy[free_idx]    <= in_disp_nzcv_ready || byp_f;
        nzcv[free_idx]     <= byp_f ? in_fu_nzcv : in_disp_nzcv;
        f_tag[free_idx]    <= in_disp_nzcv_tag;
        set_nzcv[free_idx] <= in_disp_set_nzcv;
        dst[free_idx]      <= in_disp_dst_rob_index;
      end
    end
  end

  // Issue outputs and occupancy; payload holds its last value between issues.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_fu_start         <= 1'b0;
      out_fu_op            <= '0;
      out_fu_val_a         <= '0;
      out_fu_val_b         <= '0;
      out_fu_dst_rob_index <= '0;
      out_fu_set_nzcv      <= 1'b0;
      out_fu_nzcv          <= '0;
      out_count            <= '0;
    end else if (in_flush) begin
      out_fu_start <= 1'b0;
      out_count    <= '0;
    end else begin
      out_fu_start <= issue_fire;
      if (issue_fire) begin
        out_fu_op            <= op[iss_idx];
        out_fu_val_a         <= val_a[iss_idx];
        out_fu_val_b         <= val_b[iss_idx];
        out_fu_dst_rob_index <= dst[iss_idx];
        out_fu_set_nzcv      <= set_nzcv[iss_idx];
        out_fu_nzcv          <= nzcv[iss_idx];
      end
      out_count <= out_count + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: dispatch, wakeup, bypass, backpressure,
// flags, flush and asynchronous reset.
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        disp_valid;
  logic [3:0]  disp_op;
  logic        disp_a_ready, disp_b_ready;
  logic [63:0] disp_val_a, disp_val_b;
  logic [3:0]  disp_tag_a, disp_tag_b;
  logic        disp_nzcv_ready;
  logic [3:0]  disp_nzcv;
  logic [3:0]  disp_nzcv_tag;
  logic        disp_set_nzcv;
  logic [3:0]  disp_dst;
  logic        disp_ready;
  logic        fu_done;
  logic [3:0]  fu_dst;
  logic [63:0] fu_value;
  logic        fu_set_nzcv;
  logic [3:0]  fu_nzcv;
  logic        fu_ready;
  logic        fu_start;
  logic [3:0]  fu_op;
  logic [63:0] fu_val_a, fu_val_b;
  logic [3:0]  fu_dst_out;
  logic        fu_set_nzcv_out;
  logic [3:0]  fu_nzcv_out;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  alu_issue_queue dut (
    .in_clk(clk), .in_rst(rst), .in_flush(flush),
    .in_disp_valid(disp_valid), .in_disp_op(disp_op),
    .in_disp_a_ready(disp_a_ready), .in_disp_b_ready(disp_b_ready),
    .in_disp_val_a(disp_val_a), .in_disp_val_b(disp_val_b),
    .in_disp_tag_a(disp_tag_a), .in_disp_tag_b(disp_tag_b),
    .in_disp_nzcv_ready(disp_nzcv_ready), .in_disp_nzcv(disp_nzcv),
    .in_disp_nzcv_tag(disp_nzcv_tag), .in_disp_set_nzcv(disp_set_nzcv),
    .in_disp_dst_rob_index(disp_dst), .out_disp_ready(disp_ready),
    .in_fu_done(fu_done), .in_fu_dst_rob_index(fu_dst), .in_fu_value(fu_value),
    .in_fu_set_nzcv(fu_set_nzcv), .in_fu_nzcv(fu_nzcv), .in_fu_ready(fu_ready),
    .out_fu_start(fu_start), .out_fu_op(fu_op),
    .out_fu_val_a(fu_val_a), .out_fu_val_b(fu_val_b),
    .out_fu_dst_rob_index(fu_dst_out), .out_fu_set_nzcv(fu_set_nzcv_out),
    .out_fu_nzcv(fu_nzcv_out), .out_count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic [3:0] op, input logic ar, input logic [63:0] va,
                      input logic [3:0] ta, input logic br, input logic [63:0] vb,
                      input logic [3:0] tb, input logic fr, input logic [3:0] nz,
                      input logic [3:0] ft, input logic sn, input logic [3:0] dst);
    disp_valid = 1'b1; disp_op = op;
    disp_a_ready = ar; disp_val_a = va; disp_tag_a = ta;
    disp_b_ready = br; disp_val_b = vb; disp_tag_b = tb;
    disp_nzcv_ready = fr; disp_nzcv = nz; disp_nzcv_tag = ft;
    disp_set_nzcv = sn; disp_dst = dst;
  endtask

  task automatic bcast(input logic [3:0] dst, input logic [63:0] v,
                       input logic sn, input logic [3:0] nz);
    fu_done = 1'b1; fu_dst = dst; fu_value = v; fu_set_nzcv = sn; fu_nzcv = nz;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; fu_ready = 1'b1;
    disp_valid = 1'b0; disp_op = '0;
    disp_a_ready = 1'b0; disp_b_ready = 1'b0; disp_val_a = '0; disp_val_b = '0;
    disp_tag_a = '0; disp_tag_b = '0; disp_nzcv_ready = 1'b0; disp_nzcv = '0;
    disp_nzcv_tag = '0; disp_set_nzcv = 1'b0; disp_dst = '0;
    fu_done = 1'b0; fu_dst = '0; fu_value = '0; fu_set_nzcv = 1'b0; fu_nzcv = '0;
    tick(); tick();
    chk("rst_start", fu_start, 0);
    chk("rst_count", count, 0);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_val_a", fu_val_a, 0);
    rst = 1'b0;
    tick();

    // basic all-ready op: two edges to start pulse
    disp(4'd1, 1, 64'd5, 0, 1, 64'd7, 0, 1, 4'd0, 0, 0, 4'd3);
    tick();
    disp_valid = 1'b0;
    chk("t1_count1", count, 1);
    chk("t1_nostart", fu_start, 0);
    tick();
    chk("t1_start", fu_start, 1);
    chk("t1_op", fu_op, 1);
    chk("t1_val_a", fu_val_a, 5);
    chk("t1_val_b", fu_val_b, 7);
    chk("t1_dst", fu_dst_out, 3);
    chk("t1_count0", count, 0);
    tick();
    chk("t1_pulse_end", fu_start, 0);
    chk("t1_hold_a", fu_val_a, 5);

    // operand b waits on tag 6
    disp(4'd2, 1, 64'd1, 0, 0, 64'd0, 4'd6, 1, 4'd0, 0, 0, 4'd4);
    tick();
    disp_valid = 1'b0;
    chk("t2_count", count, 1);
    tick();
    chk("t2_wait1", fu_start, 0);
    bcast(4'd6, 64'h10, 0, 4'd0);
    tick();
    fu_done = 1'b0;
    chk("t2_no_same_cycle", fu_start, 0);
    tick();
    chk("t2_start", fu_start, 1);
    chk("t2_val_b", fu_val_b, 64'h10);
    chk("t2_dst", fu_dst_out, 4);
    chk("t2_count0", count, 0);

    // bypass: broadcast same cycle as dispatch
    disp(4'd3, 0, 64'd0, 4'd2, 1, 64'd3, 0, 1, 4'd0, 0, 0, 4'd5);
    bcast(4'd2, 64'd9, 0, 4'd0);
    tick();
    disp_valid = 1'b0; fu_done = 1'b0;
    chk("t3_count", count, 1);
    chk("t3_nostart", fu_start, 0);
    tick();
    chk("t3_start", fu_start, 1);
    chk("t3_val_a", fu_val_a, 9);
    chk("t3_dst", fu_dst_out, 5);

    // backpressure: fill all four, fifth dropped, drain in index order
    fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(4'd1, 1, 64'(i + 100), 0, 1, 64'd0, 0, 1, 4'd0, 0, 0, 4'(8 + i));
      tick();
    end
    chk("t4_count4", count, 4);
    chk("t4_full", disp_ready, 0);
    disp(4'd1, 1, 64'd200, 0, 1, 64'd0, 0, 1, 4'd0, 0, 0, 4'd12);
    tick();
    disp_valid = 1'b0;
    chk("t4_drop_count", count, 4);
    chk("t4_no_issue", fu_start, 0);
    fu_ready = 1'b1;
    tick();
    chk("t4_s0", fu_start, 1); chk("t4_d0", fu_dst_out, 8);
    tick();
    chk("t4_s1", fu_start, 1); chk("t4_d1", fu_dst_out, 9);
    tick();
    chk("t4_s2", fu_start, 1); chk("t4_d2", fu_dst_out, 10);
    tick();
    chk("t4_s3", fu_start, 1); chk("t4_d3", fu_dst_out, 11);
    chk("t4_a3", fu_val_a, 103);
    tick();
    chk("t4_s_end", fu_start, 0);
    chk("t4_count0", count, 0);

    // flags wait on tag 5; a broadcast without flags must not wake them
    disp(4'd4, 1, 64'h55, 0, 1, 64'h66, 0, 0, 4'd0, 4'd5, 1, 4'd7);
    tick();
    disp_valid = 1'b0;
    bcast(4'd5, 64'd0, 0, 4'b1111);
    tick();
    fu_done = 1'b0;
    tick();
    chk("t5_still_wait", fu_start, 0);
    chk("t5_count", count, 1);
    bcast(4'd5, 64'd0, 1, 4'b0100);
    tick();
    fu_done = 1'b0;
    chk("t5_no_same", fu_start, 0);
    tick();
    chk("t5_start", fu_start, 1);
    chk("t5_nzcv", fu_nzcv_out, 4'b0100);
    chk("t5_setn", fu_set_nzcv_out, 1);
    chk("t5_dst", fu_dst_out, 7);

    // flush with concurrent dispatch
    for (int i = 0; i < 3; i++) begin
      disp(4'd1, 0, 64'd0, 4'd15, 1, 64'd0, 0, 1, 4'd0, 0, 0, 4'(i));
      tick();
    end
    chk("t6_count3", count, 3);
    disp(4'd1, 1, 64'd1, 0, 1, 64'd1, 0, 1, 4'd0, 0, 0, 4'd13);
    flush = 1'b1;
    tick();
    flush = 1'b0; disp_valid = 1'b0;
    chk("t6_flush_count", count, 0);
    chk("t6_flush_start", fu_start, 0);
    chk("t6_flush_ready", disp_ready, 1);
    tick();
    chk("t6_after_start", fu_start, 0);
    chk("t6_after_count", count, 0);
    bcast(4'd15, 64'd1, 0, 4'd0);
    tick();
    fu_done = 1'b0;
    tick();
    chk("t6_no_ghost", fu_start, 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 2; i++) begin
      disp(4'd1, 0, 64'd0, 4'd15, 1, 64'd0, 0, 1, 4'd0, 0, 0, 4'(i));
      tick();
    end
    disp_valid = 1'b0;
    chk("t7_count2", count, 2);
    #2 rst = 1'b1;
    #1;
    chk("t7_async_count", count, 0);
    chk("t7_async_ready", disp_ready, 1);
    chk("t7_async_val_a", fu_val_a, 0);
    chk("t7_async_dst", fu_dst_out, 0);
    chk("t7_async_nzcv", fu_nzcv_out, 0);
    rst = 1'b0;
    tick();
    chk("t7_post_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
